hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 131 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Hazard detection and operand forwarding for a 5-stage pipeline. It keeps
//   its own shadow copy of the ID/EX, EX/MEM and MEM/WB register fields and
//   derives from them:
//     - rs_mux/rt_mux : EX operand select (00 regfile, 01 EX/MEM, 10 MEM/WB)
//     - stall         : load-use interlock, holds PC and IF/ID for one cycle
//     - flush         : squash IF/ID on a taken branch (mirrors branch_taken)
//     - stall_count   : saturating count of load-use stall cycles
// Ports
//   clock, reset (sync, active-low)
//   id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, id_uses_rt
//   branch_taken
//   rs_mux, rt_mux, stall, flush, stall_count

// Per-operand forward select. EX/MEM is checked first because it holds the
// younger write to the same register.
module hazard_forward_sel (
  input  logic       idex_valid,
  input  logic [4:0] src,
  input  logic       ex_fwd,
  input  logic [4:0] ex_rd,
  input  logic       wb_fwd,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (idex_valid) begin
      if (ex_fwd && ex_rd == src)      sel = 2'b01;
      else if (wb_fwd && wb_rd == src) sel = 2'b10;
    end
  end
endmodule

module hazard_forward_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_uses_rt,
  input  logic        branch_taken,
  output logic [1:0]  rs_mux,
  output logic [1:0]  rt_mux,
  output logic        stall,
  output logic        flush,
  output logic [15:0] stall_count
);
  localparam int NUM_OPS = 2;  // operand 0 = rs, operand 1 = rt

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_t;

  stage_t      idex, exmem, memwb, id_entry;
  logic [15:0] cnt_q;
  logic        ex_fwd, wb_fwd, load_use;

  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0][1:0] op_sel;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid;
    id_entry.rs       = id_rs;
    id_entry.rt       = id_rt;
    id_entry.rd       = id_rd;
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
  end

  // A write to r0 is carried down the pipe but never forwarded.
  assign ex_fwd = exmem.valid && exmem.regwrite && (exmem.rd != 5'd0);
  assign wb_fwd = memwb.valid && memwb.regwrite && (memwb.rd != 5'd0);

  assign op_src[0] = idex.rs;
  assign op_src[1] = idex.rt;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hazard_forward_sel u_sel (
      .idex_valid (idex.valid),
      .src        (op_src[g]),
      .ex_fwd     (ex_fwd),
      .ex_rd      (exmem.rd),
      .wb_fwd     (wb_fwd),
      .wb_rd      (memwb.rd),
      .sel        (op_sel[g])
    );
  end

  assign rs_mux = op_sel[0];
  assign rt_mux = op_sel[1];

  // Load in EX whose result the instruction in ID needs. Only state and
  // primary inputs feed this, so stall never loops back on itself.
  assign load_use = idex.valid && idex.memread && (idex.rd != 5'd0) && id_valid &&
                    ((idex.rd == id_rs) || (id_uses_rt && idex.rd == id_rt));

  // A taken branch squashes the dependent instruction anyway, so it wins.
  assign stall       = load_use && !branch_taken;
  assign flush       = branch_taken;
  assign stall_count = cnt_q;

  // EX/MEM and MEM/WB always advance; only ID/EX takes a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
      cnt_q <= '0;
    end else begin
      memwb <= exmem;
      exmem <= idex;
      idex  <= (stall || flush) ? '0 : id_entry;
      if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Fields kept for pipeline fidelity but not consumed by any decision.
  logic unused_fields;
  assign unused_fields = ^{exmem.rs, exmem.rt, exmem.memread,
                           memwb.rs, memwb.rt, memwb.memread};
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_regwrite, id_memread, id_uses_rt, branch_taken;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  rs_mux, rt_mux;
  logic        stall, flush;
  logic [15:0] stall_count;

  int errs = 0;
  int checks = 0;

  hazard_forward_unit dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_uses_rt   (id_uses_rt),
    .branch_taken (branch_taken),
    .rs_mux       (rs_mux),
    .rt_mux       (rt_mux),
    .stall        (stall),
    .flush        (flush),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, ut, br;
    logic [1:0] ers, ert;
    logic       est, efl;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt[32];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic ut, input logic br, input logic [1:0] ers,
                              input logic [1:0] ert, input logic est, input logic efl,
                              input logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.rw = rw; r.mr = mr; r.ut = ut; r.br = br;
    r.ers = ers; r.ert = ert; r.est = est; r.efl = efl; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic ut, input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_uses_rt = ut; branch_taken = br;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ers, input logic [1:0] ert,
                         input logic est, input logic efl, input logic [15:0] ecnt);
    chk({tag, " rs_mux"}, 16'(rs_mux), 16'(ers));
    chk({tag, " rt_mux"}, 16'(rt_mux), 16'(ert));
    chk({tag, " stall"},  16'(stall),  16'(est));
    chk({tag, " flush"},  16'(flush),  16'(efl));
    chk({tag, " count"},  stall_count, ecnt);
  endtask

  initial begin
    // Expected values describe outputs after the row's inputs are applied,
    // before the following rising edge.
    vt[0]  = mk(1, 1, 2, 5, 1,0,0,0, 2'd0,2'd0,0,0,16'd0);   // add rd5
    vt[1]  = mk(1, 5, 7, 9, 1,0,1,0, 2'd0,2'd0,0,0,16'd0);   // sub rs5 rt7
    vt[2]  = mk(0, 0, 0, 0, 0,0,0,0, 2'd1,2'd0,0,0,16'd0);   // sub in EX: rs from EX/MEM
    vt[3]  = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd0,0,0,16'd0);
    vt[4]  = mk(1, 1, 2, 8, 1,0,0,0, 2'd0,2'd0,0,0,16'd0);   // add rd8
    vt[5]  = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd0,0,0,16'd0);   // nop
    vt[6]  = mk(1, 8, 3,10, 1,0,0,0, 2'd0,2'd0,0,0,16'd0);   // or rs8
    vt[7]  = mk(0, 0, 0, 0, 0,0,0,0, 2'd2,2'd0,0,0,16'd0);   // rs from MEM/WB
    vt[8]  = mk(1, 1, 2, 8, 1,0,0,0, 2'd0,2'd0,0,0,16'd0);   // add rd8
    vt[9]  = mk(1, 3, 4, 8, 1,0,0,0, 2'd0,2'd0,0,0,16'd0);   // add rd8
    vt[10] = mk(1,11, 8,12, 1,0,1,0, 2'd0,2'd0,0,0,16'd0);   // or rt8
    vt[11] = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd1,0,0,16'd0);   // EX/MEM beats MEM/WB
    vt[12] = mk(1, 1, 2, 0, 1,0,0,0, 2'd0,2'd0,0,0,16'd0);   // add rd0
    vt[13] = mk(1, 0, 0,13, 1,0,1,0, 2'd0,2'd0,0,0,16'd0);   // use r0
    vt[14] = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd0,0,0,16'd0);   // r0 never forwarded
    vt[15] = mk(1, 1, 3, 3, 1,1,0,0, 2'd0,2'd0,0,0,16'd0);   // lw rd3
    vt[16] = mk(1, 3, 4,14, 1,0,1,0, 2'd0,2'd0,1,0,16'd0);   // use rs3 -> stall
    vt[17] = mk(1, 3, 4,14, 1,0,1,0, 2'd0,2'd0,0,0,16'd1);   // held, bubble in EX
    vt[18] = mk(0, 0, 0, 0, 0,0,0,0, 2'd2,2'd0,0,0,16'd1);   // rs from MEM/WB
    vt[19] = mk(1, 1, 6, 6, 1,1,0,0, 2'd0,2'd0,0,0,16'd1);   // lw rd6
    vt[20] = mk(1, 2, 6,15, 1,0,0,0, 2'd0,2'd0,0,0,16'd1);   // rt6 but uses_rt=0
    vt[21] = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd1,0,0,16'd1);
    vt[22] = mk(1, 1, 7, 7, 1,1,0,0, 2'd0,2'd0,0,0,16'd1);   // lw rd7
    vt[23] = mk(1, 2, 7,16, 1,0,1,0, 2'd0,2'd0,1,0,16'd1);   // rt7 uses_rt -> stall
    vt[24] = mk(1, 2, 7,16, 1,0,1,0, 2'd0,2'd0,0,0,16'd2);
    vt[25] = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd2,0,0,16'd2);
    vt[26] = mk(1, 1, 3, 3, 1,1,0,0, 2'd0,2'd0,0,0,16'd2);   // lw rd3
    vt[27] = mk(1, 3, 4,17, 1,0,1,1, 2'd0,2'd0,0,1,16'd2);   // hazard + branch
    vt[28] = mk(1, 3, 4,18, 1,0,1,0, 2'd0,2'd0,0,0,16'd2);   // EX holds bubble
    vt[29] = mk(0, 0, 0, 0, 0,0,0,0, 2'd2,2'd0,0,0,16'd2);
    vt[30] = mk(1,18, 2,20, 1,0,0,1, 2'd0,2'd0,0,1,16'd2);   // flushed, would hit MEM/WB
    vt[31] = mk(0, 0, 0, 0, 0,0,0,0, 2'd0,2'd0,0,0,16'd2);

    // Reset with branch_taken high: flush still follows the input.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clock);
    #1 chk_all("reset", 2'd0, 2'd0, 1'b0, 1'b1, 16'd0);
    branch_taken = 1'b0;
    #1 chk("reset flush low", 16'(flush), 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      drive(vt[i].v, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].rw, vt[i].mr, vt[i].ut, vt[i].br);
      #1 chk_all($sformatf("vec%0d", i), vt[i].ers, vt[i].ert, vt[i].est, vt[i].efl, vt[i].ecnt);
    end

    // Saturation: preload the counter just below the limit.
    @(negedge clock);
    drive(1, 1, 3, 3, 1, 1, 0, 0);                           // lw rd3
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    @(negedge clock);
    drive(1, 3, 4, 9, 1, 0, 1, 0);
    #1 chk_all("sat stall1", 2'd0, 2'd0, 1'b1, 1'b0, 16'hFFFE);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("sat reach", stall_count, 16'hFFFF);
    @(negedge clock);
    drive(1, 1, 3, 3, 1, 1, 0, 0);
    @(negedge clock);
    drive(1, 3, 4, 9, 1, 0, 1, 0);
    #1 chk("sat stall2", 16'(stall), 16'd1);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("sat hold", stall_count, 16'hFFFF);

    // Reset in the middle of a load-use stall drops the load.
    @(negedge clock);
    drive(1, 1, 3, 3, 1, 1, 0, 0);
    @(negedge clock);
    drive(1, 3, 3, 9, 1, 0, 1, 0);
    #1 chk("midstall stall", 16'(stall), 16'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1 chk_all("post reset", 2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("no stale fwd rs", 16'(rs_mux), 16'd0);
    chk("no stale fwd rt", 16'(rt_mux), 16'd0);

    // Reset while a forward is live and a branch is taken.
    @(negedge clock);
    drive(1, 1, 2, 5, 1, 0, 0, 0);
    @(negedge clock);
    drive(1, 5, 5, 9, 1, 0, 1, 0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("pre reset fwd rs", 16'(rs_mux), 16'd1);
    chk("pre reset fwd rt", 16'(rt_mux), 16'd1);
    reset = 1'b0;
    @(negedge clock);
    #1 chk_all("final reset", 2'd0, 2'd0, 1'b0, 1'b1, 16'd0);
    reset = 1'b1;
    branch_taken = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
